pe_sequencer: RTL
=================

Name: pe_sequencer

Overview:
Program sequencer for a single PE. It holds a small configuration program of 7-bit pex_config words and, on start, issues one word per cycle to the PE. After the last word's result has been registered by the PE, it captures pe_out and signals done. The block sits between the host/config bus and the PE's pex_config input, with pe_out fed back into it.

Parameters:
DEPTH, 16, number of program slots.
AW, 4, address width; DEPTH = 2**AW.
HOLD_CFG, 7'h0F, pex_config value driven whenever no program word is being issued (both operand selects = pe_out).

Ports:
clk  in  1  clock.
reset  in  1  reset.
cfg_we  in  1  program write strobe.
cfg_addr  in  AW  program write address.
cfg_wdata  in  7  program word.
start  in  1  start request, single-cycle sampled.
prog_last  in  AW  index of last program word (program length minus 1); sampled with start.
pex_config  out  7  registered config word to PE.
pe_out_in  in  16  PE result register (pe_out).
busy  out  1  high in RUN and DRAIN.
done  out  1  one-cycle pulse, result valid.
result  out  16  captured final PE result.

Behaviour:
- One clock (clk); reset is synchronous and active-high.
- Reset, including mid-run, forces: state IDLE, pex_config=HOLD_CFG, busy=0, done=0, result=0, pc=0. Program memory is not cleared.
- Memory: DEPTH x 7. A write occurs on cfg_we in IDLE or DONE. cfg_we is ignored in RUN or DRAIN.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE: pex_config=HOLD_CFG.
  - start=1 and cfg_we=0: latch prog_last, pc=0, pex_config<=mem[0], go to RUN.
  - start=1 and cfg_we=1 in the same cycle: the write is performed and start is ignored.
- RUN: each cycle pex_config<=mem[pc+1] and pc increments.
  - When pc==last_q: pex_config<=HOLD_CFG and go to DRAIN.
  - prog_last=0 gives exactly one RUN cycle.
- DRAIN: one cycle. pe_out_in now holds the result of the last word. result<=pe_out_in, go to DONE.
- DONE: one cycle, done=1, busy=0, pex_config=HOLD_CFG.
  - start (with cfg_we=0) is accepted exactly as in IDLE, giving a back-to-back run.
  - Otherwise go to IDLE.
- start in RUN or DRAIN is ignored; no queuing.
- Timing, with start sampled at edge t:
  - pex_config=mem[k] during cycle t+1+k, for k=0..L.
  - HOLD_CFG from t+2+L.
  - result updates and done pulses in cycle t+3+L.
  - Latency start-to-done is L+3 cycles.
- result holds its value until the next DRAIN or reset.
- pc and last_q are AW bits wide and never wrap inside a single pass.

Optional Feature:
SEQ_LOOP_EN.
- Defined: adds input loop_cnt[7:0], sampled with start. The program executes loop_cnt+1 times back-to-back.
  - At pc==last_q with loops remaining, pc wraps to 0 and pex_config<=mem[0] with no gap cycle.
  - The PE accumulator state (pe_out) carries across passes.
  - DRAIN follows only the final pass. Latency is (loop_cnt+1)*(L+1)+2 cycles.
- Undefined: loop_cnt port is absent; single pass only.

Test Plan:
- Reset, then idle 3 cycles -> pex_config=7'h0F, busy=0, done=0, result=0.
- Write mem[0..2]=7'h10,7'h25,7'h3A; start with prog_last=2 -> pex_config 10,25,3A on cycles t+1..t+3, 0F at t+4; bench drives pe_out_in=16'hBEEF at t+4 -> done=1 and result=BEEF at t+5, busy high t+1..t+4.
- prog_last=0, mem[0]=7'h41, pe_out_in=16'h0007 at t+2 -> one-word issue at t+1, done at t+3, result=0007.
- start re-pulsed during RUN, plus cfg_we to addr 1 during RUN -> sequence and timing unchanged, mem[1] unchanged on the next run; start in the DONE cycle -> new RUN begins next cycle.
- Assert reset in the second RUN cycle -> next cycle pex_config=0F, busy=0, done never pulses; a fresh start replays the stored program unchanged.
- SEQ_LOOP_EN, prog_last=1, loop_cnt=2, mem[0..1]=7'h11,7'h22 -> pex_config 11,22,11,22,11,22 contiguous, then 0F; done at start+8.

Source files
------------

// File: rtl/pe_sequencer.sv
// pe_sequencer: issues a stored pex_config program to a single PE and captures the final pe_out; optional SEQ_LOOP_EN repeats the program loop_cnt+1 times
module pe_sequencer #(
    parameter int         AW       = 4,
    parameter int         DEPTH    = 2**AW,
    parameter logic [6:0] HOLD_CFG = 7'h0F
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cfg_we,
    input  logic [AW-1:0] cfg_addr,
    input  logic [6:0]    cfg_wdata,
    input  logic          start,
    input  logic [AW-1:0] prog_last,
`ifdef SEQ_LOOP_EN
    input  logic [7:0]    loop_cnt,
`endif
    output logic [6:0]    pex_config,
    input  logic [15:0]   pe_out_in,
    output logic          busy,
    output logic          done,
    output logic [15:0]   result
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t        state, state_d;
    logic [AW-1:0] pc, pc_d, pc_nxt, last_q, last_d;
    logic [6:0]    cfg_d;
    logic [15:0]   result_d;
    logic [6:0]    mem [DEPTH];
    logic          mem_we;
`ifdef SEQ_LOOP_EN
    logic [7:0]    loop_q, loop_d;
`endif

    assign busy   = (state == RUN) || (state == DRAIN);
    assign done   = (state == DONE);
    assign mem_we = cfg_we && ((state == IDLE) || (state == DONE));

    // program store: host writes only while no program is in flight
    always_ff @(posedge clk) begin
        if (mem_we) mem[cfg_addr] <= cfg_wdata;
    end

    // state and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            pc         <= '0;
            last_q     <= '0;
            pex_config <= HOLD_CFG;
            result     <= '0;
`ifdef SEQ_LOOP_EN
            loop_q     <= '0;
`endif
        end else begin
            state      <= state_d;
            pc         <= pc_d;
            last_q     <= last_d;
            pex_config <= cfg_d;
            result     <= result_d;
`ifdef SEQ_LOOP_EN
            loop_q     <= loop_d;
`endif
        end
    end

    // next state, next pc and the config word for the coming cycle
    always_comb begin
        state_d  = state;
        pc_d     = pc;
        pc_nxt   = pc + 1'b1;
        last_d   = last_q;
        cfg_d    = HOLD_CFG;
        result_d = result;
`ifdef SEQ_LOOP_EN
        loop_d   = loop_q;
`endif
        case (state)
            IDLE, DONE: begin
                if (start && !cfg_we) begin
                    state_d = RUN;
                    pc_d    = '0;
                    last_d  = prog_last;
                    cfg_d   = mem[0];
`ifdef SEQ_LOOP_EN
                    loop_d  = loop_cnt;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (pc != last_q) begin
                    pc_d  = pc_nxt;
                    cfg_d = mem[pc_nxt];
                end
`ifdef SEQ_LOOP_EN
                else if (loop_q != '0) begin
                    pc_d   = '0;
                    cfg_d  = mem[0];
                    loop_d = loop_q - 1'b1;
                end
`endif
                else begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                result_d = pe_out_in;
                state_d  = DONE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule
